pipeline_hazard_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding controller for the in-order pipeline.
//  - Tracks every in-flight register-writing op behind ID in a DEPTH-slot shift pipeline
//    (slot 0 = EX ... slot DEPTH-1 = WB).
//  - Per source operand, tells ID to stall or forward from a given slot.
//  - Supports per-op result latency (ALU, load, future multi-cycle units) and branch flush.
//  - Keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipeline_hazard_scoreboard.sv | 130 +++++++++++++
 tb/tb_pipeline_hazard_scoreboard.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard/forwarding scoreboard: tracks in-flight register writers behind ID and
// tells ID per source operand whether to stall or which slot to forward from.
module pipeline_hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 4,
  parameter int SLOT_W     = $clog2(DEPTH),
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  cpu_rst,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [SLOT_W-1:0]     issue_ready_stage,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  flush,
  output logic                  stall,
  output logic                  rs1_fwd_hit,
  output logic [SLOT_W-1:0]     rs1_fwd_slot,
  output logic                  rs2_fwd_hit,
  output logic [SLOT_W-1:0]     rs2_fwd_slot,
  output logic [DEPTH-1:0]      slot_valid,
  output logic [CNT_W-1:0]      stall_count
);

  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [REG_ADDR_W-1:0] rd_q  [DEPTH];
  logic [REG_ADDR_W-1:0] rd_d  [DEPTH];
  logic [SLOT_W-1:0]     rdy_q [DEPTH];
  logic [SLOT_W-1:0]     rdy_d [DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [REG_ADDR_W-1:0] src      [2];
  logic                  src_used [2];
  logic                  hit      [2];
  logic                  haz      [2];
  logic [SLOT_W-1:0]     fslot    [2];

  logic                  accepted;
  logic [SLOT_W-1:0]     rdy_cap;

  assign src[0]      = rs1;
  assign src[1]      = rs2;
  assign src_used[0] = rs1_used;
  assign src_used[1] = rs2_used;

  // Scan oldest to youngest so the youngest matching writer wins.
  for (genvar n = 0; n < 2; n++) begin : g_lookup
    logic              found;
    logic [SLOT_W-1:0] idx;
    always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (vld_q[i] && (rd_q[i] == src[n])) begin
          found = 1'b1;
          idx   = SLOT_W'(i);
        end
      end
      if (!src_used[n] || (src[n] == '0)) begin
        found = 1'b0;
      end
      hit[n]   = found && (idx >= rdy_q[idx]);
      haz[n]   = found && (idx <  rdy_q[idx]);
      fslot[n] = hit[n] ? idx : '0;
    end
  end

  assign stall        = issue_valid && !flush && (haz[0] || haz[1]);
  assign rs1_fwd_hit  = hit[0];
  assign rs1_fwd_slot = fslot[0];
  assign rs2_fwd_hit  = hit[1];
  assign rs2_fwd_slot = fslot[1];
  assign slot_valid   = vld_q;
  assign stall_count  = cnt_q;

  assign accepted = issue_valid && issue_we && !stall && !flush && (issue_rd != '0);

  always_comb begin
    rdy_cap = issue_ready_stage;
    if ((SLOT_W+1)'(issue_ready_stage) > (SLOT_W+1)'(DEPTH - 1)) begin
      rdy_cap = SLOT_W'(DEPTH - 1);
    end
  end

  always_comb begin
    vld_d = '0;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      rd_d[i]  = rd_q[i-1];
      rdy_d[i] = rdy_q[i-1];
    end
    // A taken branch kills the op that was in EX; older ops drain normally.
    if (flush) begin
      vld_d[1] = 1'b0;
    end
    vld_d[0] = accepted;
    rd_d[0]  = issue_rd;
    rdy_d[0] = rdy_cap;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        rdy_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= rd_d[i];
        rdy_q[i] <= rdy_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Bench for pipeline_hazard_scoreboard: directed scenarios plus random traffic
// checked against an age-based model of in-flight writers.
module tb_pipeline_hazard_scoreboard;

  localparam int DEPTH = 4;
  localparam int RW    = 4;
  localparam int SW    = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          cpu_rst;
  logic          issue_valid, issue_we, flush;
  logic [RW-1:0] issue_rd, rs1, rs2;
  logic [SW-1:0] issue_ready_stage;
  logic          rs1_used, rs2_used;
  logic          stall, rs1_fwd_hit, rs2_fwd_hit;
  logic [SW-1:0] rs1_fwd_slot, rs2_fwd_slot;
  logic [DEPTH-1:0] slot_valid;
  logic [CW-1:0] stall_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_scoreboard #(.REG_ADDR_W(RW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .cpu_rst(cpu_rst),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_ready_stage(issue_ready_stage),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .flush(flush), .stall(stall),
    .rs1_fwd_hit(rs1_fwd_hit), .rs1_fwd_slot(rs1_fwd_slot),
    .rs2_fwd_hit(rs2_fwd_hit), .rs2_fwd_slot(rs2_fwd_slot),
    .slot_valid(slot_valid), .stall_count(stall_count)
  );

  // Model: each in-flight writer is remembered by how many cycles ago it issued.
  typedef struct { int rd; int rdy; int age; } op_t;
  op_t ops[$];
  int  m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void lookup(input int rs, input int used, output int hit,
                                 output int slot, output int haz);
    int best = DEPTH;
    int brdy = 0;
    hit = 0; slot = 0; haz = 0;
    if (rs != 0 && used != 0) begin
      foreach (ops[k]) begin
        if (ops[k].rd == rs && ops[k].age < best) begin
          best = ops[k].age;
          brdy = ops[k].rdy;
        end
      end
    end
    if (best < DEPTH) begin
      if (best >= brdy) begin hit = 1; slot = best; end
      else haz = 1;
    end
  endfunction

  task automatic drive(input int iv, input int we, input int rd, input int rdy,
                       input int r1, input int u1, input int r2, input int u2, input int fl);
    issue_valid       = (iv != 0);
    issue_we          = (we != 0);
    issue_rd          = RW'(rd);
    issue_ready_stage = SW'(rdy);
    rs1               = RW'(r1);
    rs1_used          = (u1 != 0);
    rs2               = RW'(r2);
    rs2_used          = (u2 != 0);
    flush             = (fl != 0);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare all outputs against the model, then clock once and advance the model.
  task automatic tick();
    int h1, s1, z1, h2, s2, z2, est, acc, rdv;
    logic [DEPTH-1:0] esv;
    #1;
    lookup(int'(rs1), int'(rs1_used), h1, s1, z1);
    lookup(int'(rs2), int'(rs2_used), h2, s2, z2);
    est = (issue_valid && !flush && (z1 != 0 || z2 != 0)) ? 1 : 0;
    esv = '0;
    foreach (ops[k]) esv[ops[k].age] = 1'b1;
    chk("stall",        32'(stall),        est);
    chk("rs1_fwd_hit",  32'(rs1_fwd_hit),  h1);
    chk("rs1_fwd_slot", 32'(rs1_fwd_slot), s1);
    chk("rs2_fwd_hit",  32'(rs2_fwd_hit),  h2);
    chk("rs2_fwd_slot", 32'(rs2_fwd_slot), s2);
    chk("slot_valid",   32'(slot_valid),   32'(esv));
    chk("stall_count",  32'(stall_count),  m_cnt);
    acc = (issue_valid && issue_we && est == 0 && !flush && issue_rd != 0) ? 1 : 0;
    rdv = (int'(issue_ready_stage) > DEPTH - 1) ? DEPTH - 1 : int'(issue_ready_stage);
    @(posedge clk);
    for (int k = ops.size() - 1; k >= 0; k--)
      if (flush && ops[k].age == 0) ops.delete(k);
    foreach (ops[k]) ops[k].age++;
    for (int k = ops.size() - 1; k >= 0; k--)
      if (ops[k].age >= DEPTH) ops.delete(k);
    if (acc != 0) ops.push_back('{rd: int'(issue_rd), rdy: rdv, age: 0});
    if (est != 0 && m_cnt < CMAX) m_cnt++;
    @(negedge clk);
  endtask

  initial begin
    cpu_rst = 1'b0;
    idle();
    ops.delete();
    m_cnt = 0;
    #3;
    chk("rst_slot_valid", 32'(slot_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_count", 32'(stall_count), 0);
    chk("rst_hit1", 32'(rs1_fwd_hit), 0);
    @(negedge clk);
    cpu_rst = 1'b1;

    // ALU chain: result forwarded from EX the very next cycle
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0);
    #1;
    chk("alu_stall", 32'(stall), 0);
    chk("alu_hit", 32'(rs1_fwd_hit), 1);
    chk("alu_slot", 32'(rs1_fwd_slot), 0);
    tick();
    idle(); repeat (4) tick();

    // Load-use: three stall cycles then forward from slot 3
    drive(1, 1, 7, 3, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 7, 1, 0);
    repeat (3) begin
      #1 chk("ld_use_stall", 32'(stall), 1);
      chk("ld_use_nohit", 32'(rs2_fwd_hit), 0);
      tick();
    end
    #1;
    chk("ld_use_release", 32'(stall), 0);
    chk("ld_use_hit", 32'(rs2_fwd_hit), 1);
    chk("ld_use_slot", 32'(rs2_fwd_slot), 3);
    chk("ld_use_count", 32'(stall_count), 3);
    tick();
    idle(); repeat (4) tick();

    // Youngest writer wins even though an older one is ready
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 9, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 3, 3, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 3, 1, 0, 0, 0);
    #1;
    chk("young_stall", 32'(stall), 1);
    chk("young_nohit", 32'(rs1_fwd_hit), 0);
    tick();
    idle(); repeat (5) tick();

    // x0 destination and unused operands never match
    drive(1, 1, 6, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0);
    #1;
    chk("x0_hit1", 32'(rs1_fwd_hit), 0);
    chk("x0_hit2", 32'(rs2_fwd_hit), 0);
    chk("x0_stall", 32'(stall), 0);
    chk("x0_slot0", 32'(slot_valid[0]), 0);
    tick();
    idle(); repeat (4) tick();

    // Flush while a load-use hazard is pending
    drive(1, 1, 7, 3, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 7, 1, 0, 0, 1);
    #1 chk("flush_stall", 32'(stall), 0);
    tick();
    idle();
    #1 chk("flush_slots", 32'(slot_valid[1:0]), 0);
    tick();
    repeat (3) tick();

    // Random traffic against the model
    for (int c = 0; c < 500; c++) begin
      drive(($urandom_range(3, 0) != 0) ? 1 : 0, int'($urandom_range(1, 0)),
            int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
            int'($urandom_range(7, 0)), int'($urandom_range(1, 0)),
            int'($urandom_range(7, 0)), int'($urandom_range(1, 0)),
            ($urandom_range(7, 0) == 0) ? 1 : 0);
      tick();
    end
    idle(); repeat (4) tick();

    // Reset asserted between edges with all slots busy
    for (int r = 1; r <= 4; r++) begin
      drive(1, 1, r, 0, 0, 0, 0, 0, 0); tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("pre_rst_full", 32'(slot_valid), 32'hf);
    cpu_rst = 1'b0;
    #1;
    chk("mid_rst_slots", 32'(slot_valid), 0);
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_count", 32'(stall_count), 0);
    ops.delete();
    m_cnt = 0;
    idle();
    @(posedge clk);
    @(negedge clk);
    cpu_rst = 1'b1;
    tick();

    // Counter saturation: 24 stall cycles into a 4-bit counter
    for (int l = 0; l < 8; l++) begin
      drive(1, 1, 8, 3, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 8, 1, 0, 0, 0);
      repeat (3) tick();
    end
    idle();
    #1 chk("sat_count", 32'(stall_count), CMAX);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
